mac: RTL and testbench

MAC -- requirements
Module: mac

---
 rtl/mac.sv | 45 ++++
 tb/tb_mac.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mac.sv
// rtl/mac.sv - signed multiply-accumulate producing one dot product per vector
module mac #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    dsp_enable_i,
    input  logic signed [IN_W-1:0]  dsp_input_i,
    input  logic signed [IN_W-1:0]  dsp_weight_i,
    input  logic                    dsp_valid_i,
    output logic                    dsp_valid_o,
    output logic signed [OUT_W-1:0] dsp_output_o
);

    logic signed [2*IN_W-1:0] product;
    logic signed [OUT_W-1:0]  product_ext;
    logic signed [OUT_W-1:0]  acc;
    logic signed [OUT_W-1:0]  sum;

    assign product     = dsp_input_i * dsp_weight_i;
    assign product_ext = {{(OUT_W-2*IN_W){product[2*IN_W-1]}}, product};
    // Wraps silently at OUT_W bits; no saturation.
    assign sum         = acc + product_ext;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc          <= '0;
            dsp_output_o <= '0;
            dsp_valid_o  <= 1'b0;
        end else begin
            dsp_valid_o <= 1'b0;
            if (dsp_enable_i) begin
                if (dsp_valid_i) begin
                    dsp_output_o <= sum;
                    dsp_valid_o  <= 1'b1;
                    acc          <= '0;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac.sv
// tb/tb_mac.sv - randomized self-checking bench for mac against a dot-product model
module tb_mac;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               en = 1'b0;
    logic signed [7:0]  a = '0;
    logic signed [7:0]  w = '0;
    logic               last = 1'b0;
    logic               valid_o;
    logic signed [31:0] out_o;
    logic               valid_n;
    logic signed [19:0] out_n;

    int vectors = 0;
    int miscompares = 0;

    int                 vec_q[$];
    logic               exp_pulse = 1'b0;
    logic signed [31:0] exp_out = '0;
    logic signed [19:0] exp_nout = '0;

    always #5 clk = ~clk;

    mac dut (
        .clk_i(clk), .rstn_i(rstn), .dsp_enable_i(en), .dsp_input_i(a),
        .dsp_weight_i(w), .dsp_valid_i(last), .dsp_valid_o(valid_o), .dsp_output_o(out_o)
    );

    // Narrow accumulator so wrap-around is reachable in a few dozen beats.
    mac #(.IN_W(8), .OUT_W(20)) dut_n (
        .clk_i(clk), .rstn_i(rstn), .dsp_enable_i(en), .dsp_input_i(a),
        .dsp_weight_i(w), .dsp_valid_i(last), .dsp_valid_o(valid_n), .dsp_output_o(out_n)
    );

    // Drive one beat, let the edge pass, then advance the reference model.
    task automatic step(input logic r, input logic e, input logic signed [7:0] x,
                        input logic signed [7:0] y, input logic v);
        longint s;
        rstn = r; en = e; a = x; w = y; last = v;
        @(posedge clk);
        #1;
        exp_pulse = 1'b0;
        if (!r) begin
            vec_q.delete();
            exp_out  = '0;
            exp_nout = '0;
        end else if (e) begin
            vec_q.push_back(int'(x) * int'(y));
            if (v) begin
                s = 0;
                foreach (vec_q[i]) s += longint'(vec_q[i]);
                exp_out   = s[31:0];
                exp_nout  = s[19:0];
                exp_pulse = 1'b1;
                vec_q.delete();
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            vectors++;
            if (valid_o !== 1'b0 || out_o !== 32'sd0 || valid_n !== 1'b0 || out_n !== 20'sd0) begin
                miscompares++;
                $display("FAIL reset: valid=%b out=%0d valid_n=%b out_n=%0d, required 0/0", valid_o, out_o, valid_n, out_n);
            end
        end
        step(1'b1, 1'b0, 8'sd0, 8'sd0, 1'b0);
    endtask

    task automatic test_basic;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 8'(i), -8'sd1, i == 8);
            vectors++;
            if (valid_o !== exp_pulse || out_o !== exp_out) begin
                miscompares++;
                $display("FAIL basic beat %0d: valid=%b out=%0d, required %b/%0d", i, valid_o, out_o, exp_pulse, exp_out);
            end
        end
        vectors++;
        if (out_o !== -32'sd36 || valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL basic result: out=%0d valid=%b, required -36/1", out_o, valid_o);
        end
        step(1'b1, 1'b0, 8'sd5, 8'sd5, 1'b1);
        vectors++;
        if (out_o !== -32'sd36 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL basic hold: out=%0d valid=%b, required -36/0", out_o, valid_o);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 1'b1, 8'sd1, 8'sd1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1, 8'sd2, 8'sd3, i == 3);
            vectors++;
            if (valid_o !== exp_pulse || out_o !== exp_out) begin
                miscompares++;
                $display("FAIL back_to_back beat %0d: valid=%b out=%0d, required %b/%0d", i, valid_o, out_o, exp_pulse, exp_out);
            end
        end
        vectors++;
        if (out_o !== 32'sd18) begin
            miscompares++;
            $display("FAIL back_to_back result: out=%0d, required 18", out_o);
        end
    endtask

    task automatic test_gap;
        int pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 8'(i), -8'sd1, i == 8);
            pulses += int'(valid_o);
            if (i == 4) begin
                for (int g = 0; g < 2; g++) begin
                    step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b1);
                    pulses += int'(valid_o);
                end
            end
        end
        step(1'b1, 1'b0, 8'sd0, 8'sd0, 1'b0);
        pulses += int'(valid_o);
        vectors++;
        if (out_o !== -32'sd36 || pulses != 1) begin
            miscompares++;
            $display("FAIL gap: out=%0d pulses=%0d, required -36/1", out_o, pulses);
        end
    endtask

    task automatic test_single_and_wrap;
        step(1'b1, 1'b1, -8'sd128, -8'sd128, 1'b1);
        vectors++;
        if (out_o !== 32'sd16384 || valid_o !== 1'b1 || out_n !== 20'sd16384) begin
            miscompares++;
            $display("FAIL single: out=%0d valid=%b out_n=%0d, required 16384/1/16384", out_o, valid_o, out_n);
        end
        // 40 * 16129 = 645160 exceeds 2^19, so the 20-bit result wraps to -403416.
        for (int i = 1; i <= 40; i++) step(1'b1, 1'b1, 8'sd127, 8'sd127, i == 40);
        vectors++;
        if (out_o !== 32'sd645160 || out_n !== -20'sd403416 || out_n !== exp_nout) begin
            miscompares++;
            $display("FAIL wrap: out=%0d out_n=%0d, required 645160/-403416", out_o, out_n);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 8'sd9, 8'sd9, 1'b0);
        step(1'b0, 1'b1, 8'sd9, 8'sd9, 1'b1);
        pulses += int'(valid_o);
        vectors++;
        if (out_o !== 32'sd0) begin
            miscompares++;
            $display("FAIL reset_mid clear: out=%0d, required 0", out_o);
        end
        step(1'b1, 1'b1, 8'sd1, 8'sd1, 1'b0);
        pulses += int'(valid_o);
        step(1'b1, 1'b1, 8'sd2, 8'sd2, 1'b1);
        vectors++;
        if (out_o !== 32'sd5 || valid_o !== 1'b1 || pulses != 0) begin
            miscompares++;
            $display("FAIL reset_mid result: out=%0d valid=%b early_pulses=%0d, required 5/1/0", out_o, valid_o, pulses);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) >= 2), ($urandom_range(9) < 7), 8'($urandom), 8'($urandom),
                 ($urandom_range(3) == 0));
            vectors++;
            if (valid_o !== exp_pulse || out_o !== exp_out || valid_n !== exp_pulse || out_n !== exp_nout) begin
                miscompares++;
                $display("FAIL random cycle %0d: valid=%b out=%0d out_n=%0d, required %b/%0d/%0d",
                         i, valid_o, out_o, out_n, exp_pulse, exp_out, exp_nout);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_gap;
        test_single_and_wrap;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
